// File: rtl/preamble_sig_sequencer.sv
// Self-test sequencer for the midterm-preamble circuit: LFSR stimulus in, MISR signature out.
// Optional capture register and DRAIN state enabled by defining PREAMBLE_SEQ_CAPTURE_PIPE_EN.
module preamble_sig_sequencer #(
  parameter int unsigned NUM_VECTORS = 256
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        start,
  input  logic [7:0]  seed,
  output logic        busy,
  output logic        done,
  output logic [15:0] signature,
  output logic        dut_clear,
  output logic [7:0]  dut_in,
  input  logic [7:0]  dut_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [15:0] LAST_CNT = 16'(NUM_VECTORS - 1);

  state_t      r_state;
  state_t      w_nextState;
  logic [7:0]  r_lfsr;
  logic [15:0] r_vecCnt;
  logic [15:0] r_sig;
  logic        w_lfsrFb;
  logic        w_misrFb;
  logic        w_misrStep;
  logic [7:0]  w_cap;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_nextState = S_CLR;
      S_CLR:   w_nextState = S_RUN;
      S_RUN: begin
        if (r_vecCnt == LAST_CNT) begin
`ifdef PREAMBLE_SEQ_CAPTURE_PIPE_EN
          w_nextState = S_DRAIN;
`else
          w_nextState = S_DONE;
`endif
        end
      end
      S_DRAIN: w_nextState = S_DONE;
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_DONE);
    dut_clear = (r_state == S_IDLE) || (r_state == S_CLR);
    dut_in    = (r_state == S_RUN) ? r_lfsr : 8'h00;
  end

  assign w_lfsrFb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_misrFb = r_sig[15] ^ r_sig[11] ^ r_sig[4];

  // The all-zero LFSR state is a lock-up, so a zero seed is remapped to 1.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_lfsr <= 8'h01;
    end else if ((r_state == S_IDLE) && start) begin
      r_lfsr <= (seed == 8'h00) ? 8'h01 : seed;
    end else if (r_state == S_RUN) begin
      r_lfsr <= {r_lfsr[6:0], w_lfsrFb};
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_vecCnt <= 16'h0000;
    end else if (r_state == S_CLR) begin
      r_vecCnt <= 16'h0000;
    end else if (r_state == S_RUN) begin
      r_vecCnt <= r_vecCnt + 16'h0001;
    end
  end

`ifdef PREAMBLE_SEQ_CAPTURE_PIPE_EN
  logic [7:0] r_cap;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) r_cap <= 8'h00;
    else       r_cap <= dut_out;
  end

  // The register lags by one cycle: skip the first RUN cycle's stale contents, finish in DRAIN.
  assign w_cap      = r_cap;
  assign w_misrStep = ((r_state == S_RUN) && (r_vecCnt != 16'h0000)) || (r_state == S_DRAIN);
`else
  assign w_cap      = dut_out;
  assign w_misrStep = (r_state == S_RUN);
`endif

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_sig <= 16'h0000;
    end else if (r_state == S_CLR) begin
      r_sig <= 16'h0000;
    end else if (w_misrStep) begin
      r_sig <= {r_sig[14:0], w_misrFb} ^ {8'h00, w_cap};
    end
  end

  assign signature = r_sig;

endmodule

// File: tb/tb_preamble_sig_sequencer.sv
// Directed self-checking bench for preamble_sig_sequencer using an XOR-0x3C student circuit model.
module tb_preamble_sig_sequencer;

`ifdef PREAMBLE_SEQ_CAPTURE_PIPE_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic clk;
  logic clear;
  logic [7:0] seed;

  logic start1, busy1, done1, dClr1;
  logic [15:0] sig1;
  logic [7:0] dIn1, dOut1;

  logic start4, busy4, done4, dClr4;
  logic [15:0] sig4;
  logic [7:0] dIn4, dOut4;

  logic start256, busy256, done256, dClr256;
  logic [15:0] sig256;
  logic [7:0] dIn256, dOut256;

  int errCount;
  int checkCount;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dOut1   = dClr1   ? 8'h00 : (dIn1   ^ 8'h3c);
  assign dOut4   = dClr4   ? 8'h00 : (dIn4   ^ 8'h3c);
  assign dOut256 = dClr256 ? 8'h00 : (dIn256 ^ 8'h3c);

  preamble_sig_sequencer #(.NUM_VECTORS(1)) u_dut1 (
    .clk(clk), .clear(clear), .start(start1), .seed(seed),
    .busy(busy1), .done(done1), .signature(sig1),
    .dut_clear(dClr1), .dut_in(dIn1), .dut_out(dOut1)
  );

  preamble_sig_sequencer #(.NUM_VECTORS(4)) u_dut4 (
    .clk(clk), .clear(clear), .start(start4), .seed(seed),
    .busy(busy4), .done(done4), .signature(sig4),
    .dut_clear(dClr4), .dut_in(dIn4), .dut_out(dOut4)
  );

  preamble_sig_sequencer u_dut256 (
    .clk(clk), .clear(clear), .start(start256), .seed(seed),
    .busy(busy256), .done(done256), .signature(sig256),
    .dut_clear(dClr256), .dut_in(dIn256), .dut_out(dOut256)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] runVec4 [0:3];
  logic [7:0] vecs [0:255];
  int doneAt [0:7];

  initial begin
    int doneCycle;
    int busyCnt;
    int doneCnt;
    int zeroCnt;
    int firstRepeat;

    errCount   = 0;
    checkCount = 0;
    runVec4[0] = 8'hAA;
    runVec4[1] = 8'h55;
    runVec4[2] = 8'hAB;
    runVec4[3] = 8'h57;

    clear = 1'b1;
    seed = 8'h00;
    start1 = 1'b0;
    start4 = 1'b0;
    start256 = 1'b0;
    tick();
    tick();
    checkOutput("reset_busy", 32'(busy4), 32'h0);
    checkOutput("reset_done", 32'(done4), 32'h0);
    checkOutput("reset_sig", 32'(sig4), 32'h0);
    checkOutput("reset_dut_clear", 32'(dClr4), 32'h1);
    checkOutput("reset_dut_in", 32'(dIn4), 32'h0);
    clear = 1'b0;
    tick();

    // N=1, seed AA
    seed = 8'hAA;
    start1 = 1'b1;
    doneCycle = -1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) begin
        start1 = 1'b0;
        checkOutput("n1_clr_busy", 32'(busy1), 32'h1);
        checkOutput("n1_clr_dut_clear", 32'(dClr1), 32'h1);
        checkOutput("n1_clr_dut_in", 32'(dIn1), 32'h0);
      end
      if (k == 2) begin
        checkOutput("n1_run_dut_in", 32'(dIn1), 32'hAA);
        checkOutput("n1_run_dut_clear", 32'(dClr1), 32'h0);
      end
      if (done1) begin
        doneCycle = k;
        checkOutput("n1_signature", 32'(sig1), 32'h0096);
      end
    end
    checkOutput("n1_done_cycle", 32'(doneCycle), 32'(3 + EXTRA));
    checkOutput("n1_sig_held", 32'(sig1), 32'h0096);

    // N=4, seed AA
    start4 = 1'b1;
    doneCycle = -1;
    busyCnt = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) start4 = 1'b0;
      if (busy4) busyCnt++;
      if (k >= 2 && k <= 5) checkOutput($sformatf("n4_dut_in_%0d", k - 2), 32'(dIn4), 32'(runVec4[k - 2]));
      if (done4) begin
        doneCycle = k;
        checkOutput("n4_signature", 32'(sig4), 32'h0454);
      end
    end
    checkOutput("n4_busy_cycles", 32'(busyCnt), 32'(6 + EXTRA));
    checkOutput("n4_done_cycle", 32'(doneCycle), 32'(6 + EXTRA));
    checkOutput("n4_sig_held", 32'(sig4), 32'h0454);

    // clear in the third RUN cycle
    start4 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) start4 = 1'b0;
    end
    checkOutput("abort_pre_dut_in", 32'(dIn4), 32'hAB);
    checkOutput("abort_pre_sig_nonzero", 32'(sig4 != 16'h0000), 32'h1);
    #2;
    clear = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(busy4), 32'h0);
    checkOutput("abort_sig", 32'(sig4), 32'h0);
    checkOutput("abort_dut_clear", 32'(dClr4), 32'h1);
    #2;
    clear = 1'b0;
    doneCnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done4) doneCnt++;
    end
    checkOutput("abort_no_done", 32'(doneCnt), 32'h0);

    // start held high for 20 cycles
    start4 = 1'b1;
    doneCnt = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 20) start4 = 1'b0;
      if (done4) begin
        if (doneCnt < 8) doneAt[doneCnt] = k;
        doneCnt++;
        checkOutput($sformatf("held_sig_%0d", doneCnt), 32'(sig4), 32'h0454);
      end
    end
    checkOutput("held_done_count", 32'(doneCnt), 32'h3);
    if (doneCnt >= 3) begin
      checkOutput("held_first_done", 32'(doneAt[0]), 32'(6 + EXTRA));
      checkOutput("held_gap_1", 32'(doneAt[1] - doneAt[0]), 32'(7 + EXTRA));
      checkOutput("held_gap_2", 32'(doneAt[2] - doneAt[1]), 32'(7 + EXTRA));
    end

    // zero seed, full-period LFSR over 256 vectors
    seed = 8'h00;
    start256 = 1'b1;
    doneCycle = -1;
    for (int k = 1; k <= 262; k++) begin
      tick();
      if (k == 1) start256 = 1'b0;
      if (k >= 2 && k <= 257) vecs[k - 2] = dIn256;
      if (done256 && doneCycle < 0) doneCycle = k;
    end
    checkOutput("seed0_first", 32'(vecs[0]), 32'h01);
    checkOutput("seed0_second", 32'(vecs[1]), 32'h02);
    zeroCnt = 0;
    firstRepeat = -1;
    for (int i = 0; i < 256; i++) begin
      if (vecs[i] == 8'h00) zeroCnt++;
      if (i > 0 && firstRepeat < 0 && vecs[i] == vecs[0]) firstRepeat = i;
    end
    checkOutput("seed0_no_zero", 32'(zeroCnt), 32'h0);
    checkOutput("seed0_period", 32'(firstRepeat), 32'd255);
    checkOutput("seed0_done_cycle", 32'(doneCycle), 32'(258 + EXTRA));

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
